stream_rr_arbiter: RTL

Round-robin arbiter that shares one valid/ready downstream stream among NREQ upstream requesters, such as several `generator` instances feeding one `check` sink. It grants one requester per transfer and registers the selected beat in a single-entry output stage. It also tags each beat with its source index. Full throughput is one beat per cycle when downstream is always ready.

---
 rtl/stream_rr_arbiter.sv | 114 +++++++++++
 1 files changed

// File: rtl/stream_rr_arbiter.sv
// Round-robin arbiter merging NREQ valid/ready streams into one registered, source-tagged output.
// Optional per-requester accepted-beat counters: define STREAM_RR_ARB_STATS_EN.
module stream_rr_arbiter #(
  parameter int DW   = 32,
  parameter int NREQ = 4,
  localparam int IW  = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    up_valid,
  input  logic [NREQ*DW-1:0] up_data,
  output logic [NREQ-1:0]    up_ready,
  output logic               down_valid,
  output logic [DW-1:0]      down_data,
  output logic [IW-1:0]      down_src,
  input  logic               down_ready
`ifdef STREAM_RR_ARB_STATS_EN
  ,
  output logic [NREQ*16-1:0] grant_cnt
`endif
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] ptr, ptr_nxt;
  logic [DW-1:0] data_nxt;
  logic [IW-1:0] src_nxt;
  logic          load_en;
  logic          found;
  logic [IW-1:0] grant;
  logic [IW-1:0] idx;

  assign down_valid = (state == FULL);
  assign load_en    = (state == EMPTY) || down_ready;

  // First valid requester at or after ptr, wrapping modulo NREQ.
  always_comb begin : arbitrate
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    found = 1'b0;
    grant = '0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IW'((int'(ptr) + k) % NREQ);
      if (!found && up_valid[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
  end

  // Acceptance is gated by rst so nothing handshakes while the output stage is held in reset.
  always_comb begin : ready_decode
    up_ready = '0;
    if (!rst && load_en && found) up_ready[grant] = 1'b1;
  end

  always_comb begin : next_state
    state_nxt = state;
    ptr_nxt   = ptr;
    data_nxt  = down_data;
    src_nxt   = down_src;
    if (load_en) begin
      if (found) begin
        state_nxt = FULL;
        data_nxt  = up_data[int'(grant)*DW +: DW];
        src_nxt   = grant;
        ptr_nxt   = (int'(grant) == NREQ-1) ? '0 : grant + 1'b1;
      end else begin
        state_nxt = EMPTY;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      ptr       <= '0;
      down_data <= '0;
      down_src  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      down_data <= data_nxt;
      down_src  <= src_nxt;
    end
  end

`ifdef STREAM_RR_ARB_STATS_EN
  logic        hs;
  logic [15:0] cnt [NREQ];

  assign hs = load_en && found;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: this counter array is architectural state that must read zero after reset, so it is reset
      // element by element; plain data-storage arrays would normally be left unreset.
      for (int i = 0; i < NREQ; i++) cnt[i] <= '0;
    end else if (hs) begin
      cnt[grant] <= cnt[grant] + 16'd1;
    end
  end

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_cnt_out
    assign grant_cnt[gi*16 +: 16] = cnt[gi];
  end
`endif

endmodule
